// File: rtl/wb_intercon_pkg.sv
// Shared definitions for the Wishbone interconnect: bus widths, slave count,
// FSM state encoding and the default read data returned on an errored transfer.
package wb_intercon_pkg;

  localparam int unsigned NSLV   = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned ADR_W  = 32;
  localparam int unsigned DAT_W  = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WCNT_W = 8;

  localparam logic [DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERR   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/wb_intercon_addr_decode.sv
// wb_addr_decode: combinational address match and priority encoder.
// Ports: adr (address to decode), hit (some slave matched), idx (matching
// slave, lowest index wins when windows overlap).
module wb_addr_decode
  import wb_intercon_pkg::*;
#(
  parameter logic [NSLV*ADR_W-1:0] SLV_BASE = '0,
  parameter logic [NSLV*ADR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADR_W-1:0] adr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest matching slot is the last to write idx.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((adr & SLV_MASK[i*ADR_W +: ADR_W]) == SLV_BASE[i*ADR_W +: ADR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_intercon.sv
// wb_intercon: single-master, four-slave Wishbone interconnect with address
// decode, slave-ack timeout, error responses and transfer/error counters.
// Ports: clk/resetn (sync active-low); m_* master side; s_* slave side
// (s_cyc/s_stb/s_ack one bit per slave, s_dat_r slot n at [32n+31:32n]);
// err_pulse/fault_adr error reporting; xfer_cnt/err_cnt wrapping counters.
module wb_intercon
  import wb_intercon_pkg::*;
#(
  parameter logic [NSLV*ADR_W-1:0] SLV_BASE = {32'h0400_0000, 32'h0300_0000,
                                               32'h0200_0000, 32'h0100_0000},
  parameter logic [NSLV*ADR_W-1:0] SLV_MASK = {NSLV{32'hFF00_0000}},
  parameter int unsigned           TIMEOUT  = 64,
  parameter logic [DAT_W-1:0]      ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m_cyc,
  input  logic                  m_stb,
  input  logic                  m_we,
  input  logic [ADR_W-1:0]      m_adr,
  input  logic [DAT_W-1:0]      m_dat_w,
  input  logic [SEL_W-1:0]      m_sel,
  output logic                  m_ack,
  output logic [DAT_W-1:0]      m_dat_r,
  output logic [NSLV-1:0]       s_cyc,
  output logic [NSLV-1:0]       s_stb,
  output logic                  s_we,
  output logic [ADR_W-1:0]      s_adr,
  output logic [DAT_W-1:0]      s_dat_w,
  output logic [SEL_W-1:0]      s_sel,
  input  logic [NSLV-1:0]       s_ack,
  input  logic [NSLV*DAT_W-1:0] s_dat_r,
  output logic                  err_pulse,
  output logic [ADR_W-1:0]      fault_adr,
  output logic [CNT_W-1:0]      xfer_cnt,
  output logic [CNT_W-1:0]      err_cnt
);

  state_t              state;
  logic [IDX_W-1:0]    sel_q;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                err_pulse_q;
  logic [ADR_W-1:0]    fault_q;
  logic [CNT_W-1:0]    xfer_q;
  logic [CNT_W-1:0]    errc_q;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                req;
  logic                sel_ack;
  logic [DAT_W-1:0]    sel_dat;
  logic                timeout_hit;

  wb_addr_decode #(
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .adr (m_adr),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  assign req     = m_cyc & m_stb;
  assign sel_ack = s_ack[sel_q];

  // Read data of the latched slave.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q == IDX_W'(i)) sel_dat = s_dat_r[i*DAT_W +: DAT_W];
    end
  end

  // The wait count reaches TIMEOUT-1 on this edge: the last cycle spent waiting.
  assign timeout_hit = (wait_cnt == WCNT_W'(TIMEOUT - 2));

  // Transfer sequencing, counters and error capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      sel_q       <= '0;
      wait_cnt    <= '0;
      err_pulse_q <= 1'b0;
      fault_q     <= '0;
      xfer_q      <= '0;
      errc_q      <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            sel_q    <= dec_idx;
            wait_cnt <= '0;
            if (dec_hit) begin
              state <= ST_WAIT;
            end else begin
              state       <= ST_ERR;
              err_pulse_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (sel_ack) begin
            state  <= ST_DRAIN;
            xfer_q <= xfer_q + 16'd1;
          end else if (timeout_hit) begin
            state       <= ST_ERR;
            err_pulse_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ERR: begin
          state   <= ST_DRAIN;
          fault_q <= m_adr;
          xfer_q  <= xfer_q + 16'd1;
          errc_q  <= errc_q + 16'd1;
        end
        ST_DRAIN: begin
          if (!m_stb) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Slave strobes, broadcast pass-through and zero-latency ack forwarding;
  // everything is held at zero while resetn is low.
  always_comb begin
    m_ack   = 1'b0;
    m_dat_r = '0;
    s_cyc   = '0;
    s_stb   = '0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    if (resetn) begin
      s_we    = m_we;
      s_adr   = m_adr;
      s_dat_w = m_dat_w;
      s_sel   = m_sel;
      case (state)
        ST_WAIT: begin
          s_cyc[sel_q] = 1'b1;
          s_stb[sel_q] = 1'b1;
          if (req && sel_ack) begin
            m_ack   = 1'b1;
            m_dat_r = sel_dat;
          end
        end
        ST_ERR: begin
          m_ack   = 1'b1;
          m_dat_r = ERR_DATA;
        end
        default: ;
      endcase
    end
  end

  assign err_pulse = resetn & err_pulse_q;
  assign fault_adr = resetn ? fault_q : '0;
  assign xfer_cnt  = resetn ? xfer_q  : '0;
  assign err_cnt   = resetn ? errc_q  : '0;

endmodule

// File: tb/tb_wb_intercon.sv
// Self-checking bench for wb_intercon. Slot 0 is mapped at 0x0400_0000 and
// slot 1 at 0x0300_0000; 0x0500_0000 is unmapped.
module tb_wb_intercon;

  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         resetn;
  logic         m_cyc, m_stb, m_we;
  logic [31:0]  m_adr, m_dat_w;
  logic [3:0]   m_sel;
  logic         m_ack;
  logic [31:0]  m_dat_r;
  logic [3:0]   s_cyc, s_stb;
  logic         s_we;
  logic [31:0]  s_adr, s_dat_w;
  logic [3:0]   s_sel;
  logic [3:0]   s_ack;
  logic [127:0] s_dat_r;
  logic         err_pulse;
  logic [31:0]  fault_adr;
  logic [15:0]  xfer_cnt, err_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          edges;
    logic [3:0]  stb;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  wb_intercon #(
    .SLV_BASE ({32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000}),
    .TIMEOUT  (64)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_dat_w   (m_dat_w),
    .m_sel     (m_sel),
    .m_ack     (m_ack),
    .m_dat_r   (m_dat_r),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_w   (s_dat_w),
    .s_sel     (s_sel),
    .s_ack     (s_ack),
    .s_dat_r   (s_dat_r),
    .err_pulse (err_pulse),
    .fault_adr (fault_adr),
    .xfer_cnt  (xfer_cnt),
    .err_cnt   (err_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_ack = '0; s_dat_r = '0;
    step(); step();
    resetn = 1'b1;
    step();
    exp_q.delete();
  endtask

  // One master transfer; expected response is queued up front and popped when
  // m_ack appears. edges = clock edges from raising stb to the edge that
  // samples m_ack. hold = extra cycles stb stays high after the ack.
  task automatic do_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                         input int slv, input int lat, input logic [31:0] rdat,
                         input logic [3:0] noise, input int hold,
                         input logic [31:0] x_dat, input logic x_err, input int x_edges,
                         input logic [3:0] x_stb);
    exp_t e;
    int   n;
    int   wc;
    logic got;
    exp_q.push_back('{dat: x_dat, err: x_err, edges: x_edges, stb: x_stb});
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat_w = wdat; m_sel = 4'hF;
    n = 0; wc = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1; n++;
      s_ack = noise;
      if (slv >= 0 && s_stb[slv]) begin
        wc++;
        if (wc == lat) begin
          s_ack[slv] = 1'b1;
          s_dat_r[slv*32 +: 32] = rdat;
        end
      end
      #1;
      if (m_ack) begin
        got = 1'b1;
        e = exp_q.pop_front();
        total++;
        if (m_dat_r !== e.dat) begin bad++; $display("FAIL ack_data: got %h want %h", m_dat_r, e.dat); end
        total++;
        if (err_pulse !== e.err) begin bad++; $display("FAIL err_pulse: got %b want %b", err_pulse, e.err); end
        total++;
        if (n + 1 != e.edges) begin bad++; $display("FAIL ack_latency: got %0d want %0d", n + 1, e.edges); end
        total++;
        if (s_stb !== e.stb) begin bad++; $display("FAIL ack_stb: got %b want %b", s_stb, e.stb); end
      end else begin
        total++;
        if (m_dat_r !== 32'h0) begin bad++; $display("FAIL idle_data: got %h want 00000000", m_dat_r); end
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL no_ack: got none want ack within 200 cycles");
      void'(exp_q.pop_front());
    end
    for (int k = 0; k <= hold; k++) begin
      @(posedge clk); #1;
      s_ack = noise;
      if (k == hold) begin m_cyc = 1'b0; m_stb = 1'b0; end
      #1;
      total++;
      if (m_ack !== 1'b0 || s_stb !== 4'b0 || err_pulse !== 1'b0) begin
        bad++;
        $display("FAIL drain: got ack=%b stb=%b errp=%b want 0 0000 0", m_ack, s_stb, err_pulse);
      end
    end
    step();
    s_ack = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h0300_0000;
    m_dat_w = 32'h1234_5678; m_sel = 4'hF; s_ack = 4'hF; s_dat_r = '1;
    step(); step();
    total++;
    if (m_ack !== 1'b0 || m_dat_r !== 32'h0) begin bad++; $display("FAIL rst_m: got ack=%b dat=%h want 0 0", m_ack, m_dat_r); end
    total++;
    if (s_stb !== 4'h0 || s_cyc !== 4'h0) begin bad++; $display("FAIL rst_s: got stb=%b cyc=%b want 0000 0000", s_stb, s_cyc); end
    total++;
    if (s_adr !== 32'h0 || s_dat_w !== 32'h0 || s_we !== 1'b0 || s_sel !== 4'h0) begin
      bad++; $display("FAIL rst_bcast: got adr=%h dat=%h we=%b sel=%h want zeros", s_adr, s_dat_w, s_we, s_sel);
    end
    total++;
    if (xfer_cnt !== 16'h0 || err_cnt !== 16'h0 || fault_adr !== 32'h0 || err_pulse !== 1'b0) begin
      bad++; $display("FAIL rst_stat: got x=%h e=%h f=%h p=%b want zeros", xfer_cnt, err_cnt, fault_adr, err_pulse);
    end
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0; s_dat_r = '0;
    resetn = 1'b1;
    step();
    total++;
    if (s_stb !== 4'h0 || m_ack !== 1'b0) begin bad++; $display("FAIL rst_idle: got stb=%b ack=%b want 0000 0", s_stb, m_ack); end
  endtask

  task automatic test_ignored_acks();
    apply_reset();
    s_ack = 4'hF; s_dat_r = '1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (m_ack !== 1'b0 || m_dat_r !== 32'h0) begin bad++; $display("FAIL idle_ack: got ack=%b dat=%h want 0 0", m_ack, m_dat_r); end
    end
    s_ack = '0; s_dat_r = '0;
    step();
    total++;
    if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL idle_cnt: got %h want 0000", xfer_cnt); end
  endtask

  task automatic test_read_slave1();
    apply_reset();
    do_xfer(32'h0300_0004, 1'b0, 32'h0, 1, 3, 32'h0000_00A5, 4'h0, 0,
            32'h0000_00A5, 1'b0, 4, 4'b0010);
    total++;
    if (xfer_cnt !== 16'd1 || err_cnt !== 16'd0) begin bad++; $display("FAIL rd_cnt: got x=%h e=%h want 0001 0000", xfer_cnt, err_cnt); end
  endtask

  task automatic test_unmapped_write();
    apply_reset();
    do_xfer(32'h0500_0000, 1'b1, 32'hCAFE_F00D, -1, -1, 32'h0, 4'h0, 0,
            ERRD, 1'b1, 2, 4'b0000);
    total++;
    if (fault_adr !== 32'h0500_0000) begin bad++; $display("FAIL um_fault: got %h want 05000000", fault_adr); end
    total++;
    if (err_cnt !== 16'd1 || xfer_cnt !== 16'd1) begin bad++; $display("FAIL um_cnt: got e=%h x=%h want 0001 0001", err_cnt, xfer_cnt); end
  endtask

  task automatic test_timeout();
    apply_reset();
    do_xfer(32'h0400_0000, 1'b0, 32'h0, 0, -1, 32'h0, 4'h0, 0,
            ERRD, 1'b1, 65, 4'b0000);
    total++;
    if (err_cnt !== 16'd1 || fault_adr !== 32'h0400_0000) begin
      bad++; $display("FAIL to_stat: got e=%h f=%h want 0001 04000000", err_cnt, fault_adr);
    end
  endtask

  task automatic test_wrong_ack();
    apply_reset();
    do_xfer(32'h0300_0010, 1'b0, 32'h0, 1, 4, 32'h0000_5A5A, 4'b0100, 1,
            32'h0000_5A5A, 1'b0, 5, 4'b0010);
    total++;
    if (xfer_cnt !== 16'd1 || err_cnt !== 16'd0) begin bad++; $display("FAIL wa_cnt: got x=%h e=%h want 0001 0000", xfer_cnt, err_cnt); end
  endtask

  task automatic test_abort();
    apply_reset();
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0300_0000;
    step(); step();
    m_cyc = 1'b0; m_stb = 1'b0;
    step(); step();
    total++;
    if (s_stb !== 4'h0 || m_ack !== 1'b0) begin bad++; $display("FAIL abort_bus: got stb=%b ack=%b want 0000 0", s_stb, m_ack); end
    total++;
    if (xfer_cnt !== 16'd0 || err_cnt !== 16'd0) begin bad++; $display("FAIL abort_cnt: got x=%h e=%h want 0000 0000", xfer_cnt, err_cnt); end
    do_xfer(32'h0300_0020, 1'b0, 32'h0, 1, 1, 32'h0000_0077, 4'h0, 0,
            32'h0000_0077, 1'b0, 2, 4'b0010);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    do_xfer(32'h0500_0004, 1'b0, 32'h0, -1, -1, 32'h0, 4'h0, 0, ERRD, 1'b1, 2, 4'b0000);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0300_0000;
    step(); step(); step();
    total++;
    if (s_stb !== 4'b0010) begin bad++; $display("FAIL mid_wait: got %b want 0010", s_stb); end
    resetn = 1'b0;
    #1;
    total++;
    if (s_stb !== 4'h0 || xfer_cnt !== 16'h0) begin bad++; $display("FAIL mid_low: got stb=%b x=%h want 0000 0000", s_stb, xfer_cnt); end
    step();
    m_cyc = 1'b0; m_stb = 1'b0;
    resetn = 1'b1;
    step();
    total++;
    if (s_stb !== 4'h0 || m_ack !== 1'b0) begin bad++; $display("FAIL mid_idle: got stb=%b ack=%b want 0000 0", s_stb, m_ack); end
    total++;
    if (xfer_cnt !== 16'h0 || err_cnt !== 16'h0 || fault_adr !== 32'h0) begin
      bad++; $display("FAIL mid_cnt: got x=%h e=%h f=%h want zeros", xfer_cnt, err_cnt, fault_adr);
    end
    do_xfer(32'h0300_0008, 1'b0, 32'h0, 1, 2, 32'h0000_1234, 4'h0, 0,
            32'h0000_1234, 1'b0, 3, 4'b0010);
    total++;
    if (xfer_cnt !== 16'd1) begin bad++; $display("FAIL mid_after: got %h want 0001", xfer_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_xfer(32'h0200_0000, 1'b1, 32'h1111_1111, 2, 1, 32'h0000_0001, 4'h0, 1,
            32'h0000_0001, 1'b0, 2, 4'b0100);
    do_xfer(32'h0100_0000, 1'b0, 32'h0, 3, 2, 32'h0000_0002, 4'h0, 1,
            32'h0000_0002, 1'b0, 3, 4'b1000);
    total++;
    if (xfer_cnt !== 16'd2) begin bad++; $display("FAIL b2b_cnt: got %h want 0002", xfer_cnt); end
    // Start near the top of the counter range.
    force dut.xfer_q = 16'hFFFD;
    #1;
    release dut.xfer_q;
    step();
    do_xfer(32'h0100_0004, 1'b0, 32'h0, 3, 1, 32'h0000_0003, 4'h0, 0,
            32'h0000_0003, 1'b0, 2, 4'b1000);
    do_xfer(32'h0100_0008, 1'b0, 32'h0, 3, 1, 32'h0000_0004, 4'h0, 0,
            32'h0000_0004, 1'b0, 2, 4'b1000);
    total++;
    if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_top: got %h want ffff", xfer_cnt); end
    do_xfer(32'h0100_000C, 1'b0, 32'h0, 3, 1, 32'h0000_0005, 4'h0, 0,
            32'h0000_0005, 1'b0, 2, 4'b1000);
    total++;
    if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", xfer_cnt); end
  endtask

  initial begin
    resetn = 1'b0;
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_ack = '0; s_dat_r = '0;
    test_reset();
    test_ignored_acks();
    test_read_slave1();
    test_unmapped_write();
    test_timeout();
    test_wrong_ack();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard: got %0d left want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_intercon.md
WB_INTERCON -- requirements
Module: wb_intercon

Interface
REQ-001 Parameter SLV_BASE, default {32'h0400_0000, 32'h0300_0000, 32'h0200_0000, 32'h0100_0000} (4x32, slot 0 in LSBs); per-slave base address.
REQ-002 Parameter SLV_MASK, default {4{32'hFF00_0000}}; per-slave address compare mask.
REQ-003 Parameter TIMEOUT, default 64; maximum wait cycles for a slave ack (range 2..255).
REQ-004 Parameter ERR_DATA, default 32'hDEAD_BEEF; read data returned on error.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 resetn  in  1  reset, synchronous, active-low.
REQ-007 m_cyc, m_stb, m_we  in  1 each  master cycle/strobe/write.
REQ-008 m_adr, m_dat_w  in  32 each  master address and write data; m_sel  in  4  byte select.
REQ-009 m_ack  out  1  ack to master; m_dat_r  out  32  read data to master.
REQ-010 s_cyc, s_stb  out  4 each  per-slave cycle/strobe; s_we  out  1, s_adr/s_dat_w  out  32, s_sel  out  4  broadcast.
REQ-011 s_ack  in  4  per-slave ack; s_dat_r  in  128  per-slave read data, slot n at [32n+31:32n].
REQ-012 err_pulse  out  1  one-cycle pulse per errored transfer; fault_adr  out  32  address of most recent errored transfer.
REQ-013 xfer_cnt, err_cnt  out  16 each  completed-transfer and error counters.

Function
REQ-014 Decode: slave n hit when (m_adr & SLV_MASK[n]) == SLV_BASE[n]; lowest n wins on overlap; no hit = unmapped.
REQ-015 FSM states IDLE, WAIT, ERR, DRAIN; reset state IDLE.
REQ-016 IDLE: on m_cyc&m_stb, latch slave index, go WAIT if hit, else ERR; s_stb/s_cyc all zero in IDLE.
REQ-017 WAIT: s_cyc[sel]=s_stb[sel]=1 only for the latched slave; broadcast signals pass m_* through combinationally.
REQ-018 WAIT: s_ack[sel] forwarded combinationally to m_ack with s_dat_r[sel] on m_dat_r (zero added latency); next state DRAIN; xfer_cnt increments.
REQ-019 WAIT: wait counter starts at 0, increments each cycle without ack; at count TIMEOUT-1 without ack go ERR and drop s_stb.
REQ-020 WAIT: master deasserting m_stb before ack aborts to IDLE, no counters change.
REQ-021 ERR: exactly one cycle, m_ack=1, m_dat_r=ERR_DATA, err_pulse=1, fault_adr<=m_adr, err_cnt and xfer_cnt increment; next DRAIN.
REQ-022 DRAIN: m_ack=0, all s_stb=0; return to IDLE when m_stb=0; new request is not accepted in the same cycle.
REQ-023 Acks from non-selected slaves and acks in IDLE/DRAIN are ignored; m_dat_r=0 whenever m_ack=0.
REQ-024 Counters wrap 16'hFFFF -> 0 silently.
REQ-025 Error read/write both complete with ack; writes to unmapped addresses have no side effect beyond error logging.

Reset
REQ-026 resetn low at a clock edge forces state IDLE, wait counter 0, xfer_cnt=err_cnt=0, fault_adr=0, err_pulse=0, m_ack=0, all s_stb/s_cyc=0 by the next edge, including mid-transfer.
REQ-027 All outputs are 0 while resetn is low.

Structure
REQ-028 Shared package holds FSM state encoding (2 bits), slave count constant NSLV=4, and default ERR_DATA.
REQ-029 One sub-module wb_addr_decode: combinational match/priority encoder producing hit and 2-bit index.
REQ-030 No multi-cycle paths; single clock domain.

Verification
REQ-031 Read 0x0300_0004, slave 1 acks after 3 cycles with 0x0000_00A5 -> m_ack in that cycle, m_dat_r=0x0000_00A5, only s_stb[1] high, xfer_cnt=1.
REQ-032 Write 0x0500_0000 (unmapped) -> m_ack 2 cycles after strobe, m_dat_r=0xDEAD_BEEF, err_pulse 1 cycle, fault_adr=0x0500_0000, err_cnt=1.
REQ-033 Read 0x0400_0000, slave 0 never acks, TIMEOUT=64 -> ERR ack 65 cycles after strobe, s_stb[0] low from then, err_cnt=1.
REQ-034 Slave 2 asserts s_ack while slave 1 selected -> m_ack stays 0 until s_ack[1].
REQ-035 resetn low during WAIT -> next edge all s_stb=0, state IDLE, counters 0; subsequent read succeeds normally.
REQ-036 Back-to-back transfers with master holding stb one cycle after ack -> second transfer starts only after m_stb seen low; 0xFFFF transfers then one more -> xfer_cnt=0.
